// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Imported by the interface, the arbiter core and the top level.
package sram_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_LSU    = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// One requester channel: request (valid/ready + payload) and response (valid/ready + rdata).
// The requester uses the master modport, the arbiter uses the slave modport.
interface sram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/sram_port_arbiter_rr.sv
// Two-way grant: round-robin on ties (or port 1 always wins when FIXED_PRIO != 0).
// The last-grant register only moves on an accept strobe, so an unaccepted grant does not rotate.
module rr_arbiter_2
    import sram_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_id = PORT_IFETCH;
        if (req[0] && req[1]) begin
            if (FIXED_PRIO != 0) begin
                gnt_id = PORT_LSU;
            end else begin
                gnt_id = ~last_q;
            end
        end else if (req[1]) begin
            gnt_id = PORT_LSU;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (req != 2'b00) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    assign last_d = accept ? gnt_id : last_q;

    // "last = LSU" out of reset makes the first tie go to instruction fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_LSU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single read/write port of the 32x32 SRAM macro between instruction fetch (p0)
// and load/store (p1); sequences each access to the macro's posedge-sample / negedge-access timing.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_port_arbiter_if.slave    p0,
    sram_port_arbiter_if.slave    p1,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  busy
);

    state_e                     state_q, state_d;
    logic                       gnt_id_q, gnt_id_d;
    logic                       we_q, we_d;
    logic                       csb_q, csb_d;
    logic                       web_q, web_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      din_q, din_d;
    logic [1:0]                 rsp_valid_q, rsp_valid_d;
    logic [1:0][DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0]                 req_valid;
    logic [1:0]                 rsp_ready;
    logic [1:0]                 gnt;
    logic                       win_id;
    logic                       accept;
    logic                       win_we;
    logic [ADDR_WIDTH-1:0]      win_addr;
    logic [DATA_WIDTH-1:0]      win_wdata;

    assign req_valid = {p1.req_valid, p0.req_valid};
    assign rsp_ready = {p1.rsp_ready, p0.rsp_ready};
    assign accept    = (state_q == IDLE) && (req_valid != 2'b00);

    rr_arbiter_2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .gnt    (gnt),
        .gnt_id (win_id)
    );

    assign win_we    = (win_id == PORT_LSU) ? p1.req_we    : p0.req_we;
    assign win_addr  = (win_id == PORT_LSU) ? p1.req_addr  : p0.req_addr;
    assign win_wdata = (win_id == PORT_LSU) ? p1.req_wdata : p0.req_wdata;

    // Ready is only offered in IDLE, so at most one transaction is ever in flight.
    assign p0.req_ready = (state_q == IDLE) && gnt[PORT_IFETCH];
    assign p1.req_ready = (state_q == IDLE) && gnt[PORT_LSU];

    assign p0.rsp_valid = rsp_valid_q[PORT_IFETCH];
    assign p1.rsp_valid = rsp_valid_q[PORT_LSU];
    assign p0.rsp_rdata = rsp_rdata_q[PORT_IFETCH];
    assign p1.rsp_rdata = rsp_rdata_q[PORT_LSU];

    assign sram_csb0  = csb_q;
    assign sram_web0  = web_q;
    assign sram_addr0 = addr_q;
    assign sram_din0  = din_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        we_d        = we_q;
        csb_d       = csb_q;
        web_d       = web_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_id_d = win_id;
                    we_d     = win_we;
                    addr_d   = win_addr;
                    din_d    = win_wdata;
                    csb_d    = 1'b0;
                    web_d    = ~win_we;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // The macro latches csb/web/addr/din at this edge; deselect right after.
                csb_d   = 1'b1;
                web_d   = 1'b1;
                state_d = CAPT;
            end
            CAPT: begin
                // dout0 settled on the negedge inside this cycle.
                rsp_rdata_d[gnt_id_q] = we_q ? '0 : sram_dout0;
                rsp_valid_d[gnt_id_q] = 1'b1;
                state_d               = RESP;
            end
            RESP: begin
                if (rsp_ready[gnt_id_q]) begin
                    rsp_valid_d[gnt_id_q] = 1'b0;
                    state_d               = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_id_q    <= PORT_IFETCH;
            we_q        <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            we_q        <= we_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a behavioural SRAM macro model plus table-driven
// transactions and hand-written sequences for arbitration, response stall and mid-access reset.
module tb_sram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p0_if ();
    sram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p1_if ();
    sram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p0f_if ();
    sram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p1f_if ();

    logic          sram_csb0, sram_web0, busy;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;

    logic          f_csb0, f_web0, f_busy;
    logic [AW-1:0] f_addr0;
    logic [DW-1:0] f_din0;
    logic [DW-1:0] f_dout0 = '0;

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .p0         (p0_if),
        .p1         (p1_if),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0),
        .busy       (busy)
    );

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(1)) dut_fp (
        .clk        (clk),
        .rst        (rst),
        .p0         (p0f_if),
        .p1         (p1f_if),
        .sram_csb0  (f_csb0),
        .sram_web0  (f_web0),
        .sram_addr0 (f_addr0),
        .sram_din0  (f_din0),
        .sram_dout0 (f_dout0),
        .busy       (f_busy)
    );

    // SRAM macro model: inputs latched on posedge, array access on negedge; no reset.
    logic [DW-1:0] mem [0:31] = '{31: 32'h12345678, default: 32'h0};
    logic          s_csb = 1'b1;
    logic          s_web = 1'b1;
    logic [AW-1:0] s_addr = '0;
    logic [DW-1:0] s_din = '0;

    always @(posedge clk) begin
        s_csb  <= sram_csb0;
        s_web  <= sram_web0;
        s_addr <= sram_addr0;
        s_din  <= sram_din0;
    end

    always @(negedge clk) begin
        if (!s_csb) begin
            if (!s_web) mem[s_addr] <= s_din;
            else        sram_dout0  <= mem[s_addr];
        end
    end

    int csb_lo_cnt = 0;
    int wr_lo_cnt  = 0;
    always @(negedge clk) begin
        if (!sram_csb0)               csb_lo_cnt <= csb_lo_cnt + 1;
        if (!sram_csb0 && !sram_web0) wr_lo_cnt  <= wr_lo_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input bit port, input bit v, input bit we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port) begin
            p1_if.req_valid = v; p1_if.req_we = we; p1_if.req_addr = addr; p1_if.req_wdata = wdata;
        end else begin
            p0_if.req_valid = v; p0_if.req_we = we; p0_if.req_addr = addr; p0_if.req_wdata = wdata;
        end
    endtask

    function automatic logic rsp_v(input bit port);
        return port ? p1_if.rsp_valid : p0_if.rsp_valid;
    endfunction

    function automatic logic [DW-1:0] rsp_d(input bit port);
        return port ? p1_if.rsp_rdata : p0_if.rsp_rdata;
    endfunction

    function automatic logic req_r(input bit port);
        return port ? p1_if.req_ready : p0_if.req_ready;
    endfunction

    // Wait (bounded) for req_ready on a negedge; the accept happens at the following posedge.
    task automatic wait_ready(input string name, input bit port, output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_r(port)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check({name, "_accept_timeout"}, 0, 1);
    endtask

    task automatic wait_rsp(input string name, input bit port, output int lat);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (rsp_v(port)) begin
                lat = n;
                break;
            end
        end
        check({name, "_latency"}, lat, 2);
    endtask

    task automatic do_txn(input string name, input bit port, input bit we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp);
        int  c0, w0, lat;
        bit  got;
        @(posedge clk); #1;
        drive_req(port, 1'b1, we, addr, wdata);
        wait_ready(name, port, got);
        if (!got) begin
            drive_req(port, 1'b0, we, addr, wdata);
            return;
        end
        c0 = csb_lo_cnt;
        w0 = wr_lo_cnt;
        @(posedge clk); #1;
        drive_req(port, 1'b0, we, addr, wdata);
        wait_rsp(name, port, lat);
        if (lat == 0) return;
        check({name, "_rdata"}, rsp_d(port), exp);
        check({name, "_other_valid"}, rsp_v(~port), 0);
        check({name, "_csb_cycles"}, csb_lo_cnt - c0, 1);
        check({name, "_wr_cycles"}, wr_lo_cnt - w0, we ? 1 : 0);
        @(posedge clk); #1;
        check({name, "_rsp_clear"}, rsp_v(port), 0);
        check({name, "_idle"}, busy, 0);
    endtask

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [8];
    int   gq [$];
    int   fq [$];

    initial begin
        bit got;
        int lat;

        vecs[0] = '{1'b1, 1'b1, 5'h03, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 5'h03, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 5'h00, 32'hAAAA5555, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 5'h1F, 32'h5555AAAA, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 5'h00, 32'h0,        32'hAAAA5555};
        vecs[5] = '{1'b1, 1'b0, 5'h1F, 32'h0,        32'h5555AAAA};
        vecs[6] = '{1'b1, 1'b1, 5'h10, 32'h0F0F0F0F, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 5'h10, 32'h0,        32'h0F0F0F0F};

        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        p0_if.rsp_ready = 1'b1;
        p1_if.rsp_ready = 1'b1;
        p0f_if.req_valid = 1'b0; p0f_if.req_we = 1'b0; p0f_if.req_addr = 5'h01; p0f_if.req_wdata = '0;
        p1f_if.req_valid = 1'b0; p1f_if.req_we = 1'b0; p1f_if.req_addr = 5'h01; p1f_if.req_wdata = '0;
        p0f_if.rsp_ready = 1'b1;
        p1f_if.rsp_ready = 1'b1;

        // Reset values
        @(posedge clk); @(posedge clk); #1;
        check("rst_csb", sram_csb0, 1);
        check("rst_web", sram_web0, 1);
        check("rst_addr", sram_addr0, 0);
        check("rst_din", sram_din0, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", {p1_if.rsp_valid, p0_if.rsp_valid}, 0);
        rst = 1'b0;

        // Arbitration: both ports request continuously on both instances
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 1'b0, 5'h01, '0);
        drive_req(1'b1, 1'b1, 1'b0, 5'h01, '0);
        p0f_if.req_valid = 1'b1;
        p1f_if.req_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (p0_if.req_ready)  gq.push_back(0);
            if (p1_if.req_ready)  gq.push_back(1);
            if (p0f_if.req_ready) fq.push_back(0);
            if (p1f_if.req_ready) fq.push_back(1);
            if (gq.size() >= 4 && fq.size() >= 4) break;
        end
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, 5'h01, '0);
        drive_req(1'b1, 1'b0, 1'b0, 5'h01, '0);
        p0f_if.req_valid = 1'b0;
        p1f_if.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_grant%0d", k), (gq.size() > k) ? gq[k] : 2, k % 2);
            check($sformatf("fixed_grant%0d", k), (fq.size() > k) ? fq[k] : 2, 1);
        end
        for (int i = 0; i < 20 && (busy || f_busy); i++) @(posedge clk);
        #1;
        check("arb_drain", {busy, f_busy}, 0);

        // Response stall: p0 reads 5'h1F while p1 waits
        @(posedge clk); #1;
        p0_if.rsp_ready = 1'b0;
        drive_req(1'b0, 1'b1, 1'b0, 5'h1F, '0);
        wait_ready("stall", 1'b0, got);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, 5'h1F, '0);
        drive_req(1'b1, 1'b1, 1'b0, 5'h1F, '0);
        wait_rsp("stall", 1'b0, lat);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            check($sformatf("stall_valid%0d", c), p0_if.rsp_valid, 1);
            check($sformatf("stall_rdata%0d", c), p0_if.rsp_rdata, 32'h12345678);
            check($sformatf("stall_busy%0d", c), busy, 1);
            check($sformatf("stall_p1_ready%0d", c), p1_if.req_ready, 0);
        end
        p0_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("release_busy", busy, 0);
        check("release_valid", p0_if.rsp_valid, 0);
        check("release_p1_ready", p1_if.req_ready, 1);
        @(posedge clk); #1;
        drive_req(1'b1, 1'b0, 1'b0, 5'h1F, '0);
        wait_rsp("p1_after_stall", 1'b1, lat);
        check("p1_after_stall_rdata", p1_if.rsp_rdata, 32'h12345678);
        @(posedge clk); #1;

        // Table-driven transactions
        for (int v = 0; v < 8; v++) begin
            do_txn($sformatf("vec%0d", v), vecs[v].port, vecs[v].we, vecs[v].addr,
                   vecs[v].wdata, vecs[v].exp);
        end

        // Reset during ISSUE: the write never reaches the array
        @(posedge clk); #1;
        drive_req(1'b1, 1'b1, 1'b1, 5'h07, 32'hCAFEF00D);
        wait_ready("rst_issue", 1'b1, got);
        @(posedge clk); #1;
        drive_req(1'b1, 1'b0, 1'b1, 5'h07, 32'hCAFEF00D);
        check("rst_issue_csb_before", sram_csb0, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_issue_csb", sram_csb0, 1);
        check("rst_issue_web", sram_web0, 1);
        check("rst_issue_addr", sram_addr0, 0);
        check("rst_issue_din", sram_din0, 0);
        check("rst_issue_busy", busy, 0);
        check("rst_issue_rsp_valid", {p1_if.rsp_valid, p0_if.rsp_valid}, 0);
        check("rst_issue_p0_rdata", p0_if.rsp_rdata, 0);
        check("rst_issue_p1_rdata", p1_if.rsp_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_txn("rst_issue_readback", 1'b0, 1'b0, 5'h07, '0, 32'h0);

        // Reset during CAPT: the write lands but no response appears
        @(posedge clk); #1;
        drive_req(1'b1, 1'b1, 1'b1, 5'h07, 32'hCAFEF00D);
        wait_ready("rst_capt", 1'b1, got);
        @(posedge clk); #1;
        drive_req(1'b1, 1'b0, 1'b1, 5'h07, 32'hCAFEF00D);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rst_capt_no_rsp%0d", c), {p1_if.rsp_valid, p0_if.rsp_valid, busy}, 0);
            @(posedge clk); #1;
        end
        do_txn("rst_capt_readback", 1'b0, 1'b0, 5'h07, '0, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
